// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end and the door-lock FSM:
// scan FSM state encoding, named key codes and the row/column key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_RELEASE
  } state_t;

  // Codes with special meaning to the lock controller (enter/clear decoding).
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Physical keypad layout: row 0 at the top, column 0 at the left.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous level inputs. Resets to all ones
// because the keypad row lines idle high; a zero reset value would look like
// every key pressed at once.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  // NOTE: non-blocking assignments make meta->q a real two-flop chain; blocking ones would collapse it to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner, debouncer and encoder. Each accepted press is
// delivered once over a valid/ready handshake. Define KEYPAD_FIFO_EN to
// replace the single holding register with a 4-entry FIFO.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_overrun,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DWELL) + 1;
  localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rs_n;
  state_t        state, state_d;
  logic [1:0]    col, col_d;
  logic [1:0]    row, row_d;
  logic [DW-1:0] dwell, dwell_d;
  logic [BW-1:0] deb, deb_d, deb_inc;
  logic [3:0]    pat, pat_d;
  logic          held_d;
  logic          one_low;
  logic [1:0]    low_idx;
  logic          push;
  logic [3:0]    push_code;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (row_n),
    .q     (rs_n)
  );

  assign col_n   = ~(4'b0001 << col);
  assign deb_inc = (deb == '1) ? deb : deb + 1'b1;

  // Identify a single low row; none or several low (ghosting) is not a press.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    one_low = 1'b0;
    low_idx = 2'd0;
    case (rs_n)
      4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
      default: ;
    endcase
  end

  // Scan/debounce/release next-state logic and the push strobe.
  always_comb begin
    state_d   = state;
    col_d     = col;
    row_d     = row;
    dwell_d   = dwell;
    deb_d     = deb;
    pat_d     = pat;
    held_d    = key_held;
    push      = 1'b0;
    push_code = key_map(row, col);
    case (state)
      ST_SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            row_d   = low_idx;
            pat_d   = rs_n;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col + 1'b1;
          end
        end else begin
          dwell_d = dwell + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (rs_n == pat) begin
          if (deb == DEB_LAST) begin
            push    = 1'b1;
            held_d  = 1'b1;
            deb_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            deb_d = deb_inc;
          end
        end else begin
          deb_d   = '0;
          col_d   = col + 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_RELEASE: begin
        if (rs_n == 4'b1111) begin
          if (deb == DEB_LAST) begin
            held_d  = 1'b0;
            deb_d   = '0;
            col_d   = '0;
            dwell_d = '0;
            state_d = ST_SCAN;
          end else begin
            deb_d = deb_inc;
          end
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Scanner state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SCAN;
      col      <= '0;
      row      <= '0;
      dwell    <= '0;
      deb      <= '0;
      pat      <= '1;
      key_held <= 1'b0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      row      <= row_d;
      dwell    <= dwell_d;
      deb      <= deb_d;
      pat      <= pat_d;
      key_held <= held_d;
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic [3:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       pop, full, wr_en;

  assign pop       = key_valid & key_ready;
  assign full      = (count == 3'd4);
  assign wr_en     = push & (~full | pop);
  assign key_valid = (count != 3'd0);
  assign key_code  = key_valid ? fifo_mem[rd_ptr] : 4'h0;

  // FIFO storage write port.
  // NOTE: storage is not reset; key_valid gates key_code, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= push_code;
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= push & full & ~pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  // Single holding register; a push during a pending key is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (push) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= push_code;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural 4x4 key matrix.
// Build with KEYPAD_FIFO_EN defined to exercise the FIFO output stage.
module tb_keypad_encoder;

  localparam int SD  = 3;
  localparam int DB  = 4;
  localparam int LAT = 4 * SD + DB + 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n, col_n, key_code;
  logic       key_valid, key_ready, key_overrun, key_held;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int ov_count = 0;
  logic [3:0] acc_q[$];

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Key matrix: a row reads low when a pressed key in it sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  keypad_encoder #(.SCAN_DWELL(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_overrun (key_overrun),
    .key_held    (key_held)
  );

  // Record handshakes about to complete and overrun pulses.
  always @(negedge clk) begin
    if (reset === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) acc_q.push_back(key_code);
    if (reset === 1'b1 && key_overrun === 1'b1) ov_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    key_ready = v;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_held(input logic want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (key_held === want) ok = 1'b1;
    end
  endtask

  // Press (optionally with 1-cycle bounces), expect one delivered code, release.
  task automatic press_key(input int row, input int col, input logic [3:0] exp,
                           input int bounces, input string name);
    bit ok;
    int n0;
    n0 = acc_q.size();
    for (int i = 0; i < 2 * bounces; i++) begin
      keys[row*4 + col] = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    keys[row*4 + col] = 1'b1;
    wait_valid((bounces > 0) ? LAT + 4 * SD : LAT, ok);
    check({name, " latency"}, 32'(ok), 1);
    check({name, " code"}, 32'(key_code), 32'(exp));
    repeat (8) @(negedge clk);
    check({name, " held"}, 32'(key_held), 1);
    keys[row*4 + col] = 1'b0;
    wait_held(1'b0, 20, ok);
    check({name, " release"}, 32'(ok), 1);
    repeat (2) @(negedge clk);
    check({name, " pushes"}, 32'(acc_q.size() - n0), 1);
    if (acc_q.size() > n0) check({name, " accepted"}, 32'(acc_q[n0]), 32'(exp));
  endtask

  initial begin
    bit ok;
    int n0, ov0, same;
    logic [3:0] last;
    bit found, held_seen, valid_seen, col3_seen;

    vecs[0] = '{0, 0, 4'h1};
    vecs[1] = '{0, 3, 4'hA};
    vecs[2] = '{2, 1, 4'h8};
    vecs[3] = '{3, 1, 4'h0};
    vecs[4] = '{3, 2, 4'hF};
    vecs[5] = '{3, 3, 4'hD};
    vecs[6] = '{1, 3, 4'hB};
    vecs[7] = '{2, 2, 4'h9};

    // Reset values
    keys = '0;
    key_ready = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst col_n", 32'(col_n), 32'hE);
    check("rst valid", 32'(key_valid), 0);
    check("rst code", 32'(key_code), 0);
    check("rst held", 32'(key_held), 0);
    check("rst overrun", 32'(key_overrun), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: clean press of "6" while column 2 is driven
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (col_n == 4'b1011) found = 1'b1;
    end
    check("t1 col2 driven", 32'(found), 1);
    press_key(1, 2, 4'h6, 0, "t1");

    // 2: "*" with three 1-cycle bounces
    press_key(3, 0, 4'hE, 3, "t2");

    // Key map table
    for (int v = 0; v < 8; v++) press_key(vecs[v].row, vecs[v].col, vecs[v].code, 0, $sformatf("vec%0d", v));

    // 4: rows 0 and 2 low on column 1, then row 2 releases
    n0 = acc_q.size();
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    held_seen = 1'b0;
    valid_seen = 1'b0;
    col3_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_held) held_seen = 1'b1;
      if (key_valid) valid_seen = 1'b1;
      if (col_n == 4'b0111) col3_seen = 1'b1;
    end
    check("t4 multi held", 32'(held_seen), 0);
    check("t4 multi valid", 32'(valid_seen), 0);
    check("t4 scan continues", 32'(col3_seen), 1);
    keys[9] = 1'b0;
    wait_valid(LAT, ok);
    check("t4 latency", 32'(ok), 1);
    check("t4 code", 32'(key_code), 32'h2);
    keys[1] = 1'b0;
    wait_held(1'b0, 20, ok);
    check("t4 release", 32'(ok), 1);
    repeat (2) @(negedge clk);
    check("t4 pushes", 32'(acc_q.size() - n0), 1);

`ifdef KEYPAD_FIFO_EN
    // 6: five keys into a 4-entry FIFO with the consumer stalled
    set_ready(1'b0);
    n0 = acc_q.size();
    ov0 = ov_count;
    for (int k = 0; k < 5; k++) begin
      keys[(k < 3) ? k : k + 1] = 1'b1;
      wait_held(1'b1, LAT, ok);
      check($sformatf("t6 push%0d", k), 32'(ok), 1);
      keys = '0;
      wait_held(1'b0, 20, ok);
    end
    repeat (2) @(negedge clk);
    check("t6 overrun", 32'(ov_count - ov0), 1);
    check("t6 valid", 32'(key_valid), 1);
    check("t6 head", 32'(key_code), 32'h1);
    set_ready(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (key_valid === 1'b0) ok = 1'b1;
    end
    check("t6 drained", 32'(ok), 1);
    check("t6 count", 32'(acc_q.size() - n0), 4);
    for (int k = 0; k < 4; k++)
      if (acc_q.size() > n0 + k) check($sformatf("t6 order%0d", k), 32'(acc_q[n0 + k]), 32'(k + 1));
`else
    // 3: "1" then "2" with the consumer stalled
    set_ready(1'b0);
    n0 = acc_q.size();
    ov0 = ov_count;
    keys[0] = 1'b1;
    wait_valid(LAT, ok);
    check("t3 first valid", 32'(ok), 1);
    check("t3 first code", 32'(key_code), 32'h1);
    keys[0] = 1'b0;
    wait_held(1'b0, 20, ok);
    keys[1] = 1'b1;
    wait_held(1'b1, LAT, ok);
    check("t3 second push", 32'(ok), 1);
    keys[1] = 1'b0;
    wait_held(1'b0, 20, ok);
    check("t3 overrun", 32'(ov_count - ov0), 1);
    check("t3 kept valid", 32'(key_valid), 1);
    check("t3 kept code", 32'(key_code), 32'h1);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t3 valid cleared", 32'(key_valid), 0);
    check("t3 accepts", 32'(acc_q.size() - n0), 1);
    if (acc_q.size() > n0) check("t3 accepted", 32'(acc_q[n0]), 32'h1);
`endif

    // 5: reset during a pending key and during debounce of another
    set_ready(1'b0);
    keys[5] = 1'b1;
    wait_valid(LAT, ok);
    check("t5 valid", 32'(ok), 1);
    check("t5 code", 32'(key_code), 32'h5);
    keys[5] = 1'b0;
    wait_held(1'b0, 20, ok);
    keys[10] = 1'b1;
    same = 0;
    last = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_n == last) same++;
      else same = 1;
      last = col_n;
      if (same >= 4) found = 1'b1;
    end
    check("t5 in debounce", 32'(found), 1);
    check("t5 pre held", 32'(key_held), 0);
    check("t5 pre valid", 32'(key_valid), 1);
    #1 reset = 1'b0;
    #1;
    check("t5 rst col_n", 32'(col_n), 32'hE);
    check("t5 rst valid", 32'(key_valid), 0);
    check("t5 rst code", 32'(key_code), 0);
    check("t5 rst held", 32'(key_held), 0);
    check("t5 rst overrun", 32'(key_overrun), 0);
    keys = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t5 restart col", 32'(col_n), 32'hE);
    repeat (30) @(negedge clk);
    check("t5 no key", 32'(key_valid), 0);
    check("t5 not held", 32'(key_held), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
